// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with EX-side forwarding and load-use stall
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RIDX = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RIDX-1:0] id_rs1,
    input  logic [RIDX-1:0] id_rs2,
    input  logic [RIDX-1:0] id_rd,
    input  logic [2:0]      id_alusel,
    input  logic            id_asel,
    input  logic            id_bsel,
    input  logic            id_regwen,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            flush,
    input  logic [RIDX-1:0] mem_rd,
    input  logic            mem_regwen,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RIDX-1:0] wb_rd,
    input  logic            wb_regwen,
    input  logic [XLEN-1:0] wb_result,
    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_operand1,
    output logic [XLEN-1:0] ex_operand2,
    output logic [2:0]      ex_alusel,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RIDX-1:0] ex_rd,
    output logic            ex_regwen,
    output logic            ex_memread,
    output logic            ex_memwrite
);

    logic            valid_q,    valid_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q,      imm_d;
    logic [RIDX-1:0] rs1_q,      rs1_d;
    logic [RIDX-1:0] rs2_q,      rs2_d;
    logic [RIDX-1:0] rd_q,       rd_d;
    logic [2:0]      alusel_q,   alusel_d;
    logic            asel_q,     asel_d;
    logic            bsel_q,     bsel_d;
    logic            regwen_q,   regwen_d;
    logic            memread_q,  memread_d;
    logic            memwrite_q, memwrite_d;

    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;

    always_comb begin
        stall = valid_q & memread_q & (rd_q != '0) & id_valid
              & ((rd_q == id_rs1) | (rd_q == id_rs2));
    end

    // Flush, stall and an empty ID slot all load a zeroed bubble.
    always_comb begin
        valid_d    = 1'b0;
        pc_d       = '0;
        rs1_data_d = '0;
        rs2_data_d = '0;
        imm_d      = '0;
        rs1_d      = '0;
        rs2_d      = '0;
        rd_d       = '0;
        alusel_d   = '0;
        asel_d     = 1'b0;
        bsel_d     = 1'b0;
        regwen_d   = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        if (!flush && !stall && id_valid) begin
            valid_d    = 1'b1;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            alusel_d   = id_alusel;
            asel_d     = id_asel;
            bsel_d     = id_bsel;
            regwen_d   = id_regwen;
            memread_d  = id_memread;
            memwrite_d = id_memwrite;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alusel_q   <= '0;
            asel_q     <= 1'b0;
            bsel_q     <= 1'b0;
            regwen_q   <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            alusel_q   <= alusel_d;
            asel_q     <= asel_d;
            bsel_q     <= bsel_d;
            regwen_q   <= regwen_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
        end
    end

    // EX/MEM is younger than MEM/WB, so it is checked first; x0 never forwards.
    always_comb begin
        fwd1 = rs1_data_q;
        if (mem_regwen && (mem_rd != '0) && (mem_rd == rs1_q)) begin
            fwd1 = mem_result;
        end else if (wb_regwen && (wb_rd != '0) && (wb_rd == rs1_q)) begin
            fwd1 = wb_result;
        end
    end

    always_comb begin
        fwd2 = rs2_data_q;
        if (mem_regwen && (mem_rd != '0) && (mem_rd == rs2_q)) begin
            fwd2 = mem_result;
        end else if (wb_regwen && (wb_rd != '0) && (wb_rd == rs2_q)) begin
            fwd2 = wb_result;
        end
    end

    always_comb begin
        ex_valid      = valid_q;
        ex_pc         = pc_q;
        ex_operand1   = asel_q ? pc_q : fwd1;
        ex_operand2   = bsel_q ? imm_q : fwd2;
        ex_store_data = fwd2;
        ex_alusel     = alusel_q & {3{valid_q}};
        ex_rd         = rd_q;
        ex_regwen     = regwen_q & valid_q;
        ex_memread    = memread_q & valid_q;
        ex_memwrite   = memwrite_q & valid_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and randomized bench for id_ex_stage against an instruction-level model
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_alusel;
    logic        id_asel, id_bsel, id_regwen, id_memread, id_memwrite;
    logic        flush;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_regwen, wb_regwen;
    logic [31:0] mem_result, wb_result;
    logic        stall, ex_valid;
    logic [31:0] ex_pc, ex_operand1, ex_operand2, ex_store_data;
    logic [2:0]  ex_alusel;
    logic [4:0]  ex_rd;
    logic        ex_regwen, ex_memread, ex_memwrite;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        v;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  alu;
        logic        asel, bsel, rw, mr, mw;
    } ins_t;

    ins_t m;
    logic last_stall;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alusel(id_alusel),
        .id_asel(id_asel), .id_bsel(id_bsel), .id_regwen(id_regwen),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .flush(flush),
        .mem_rd(mem_rd), .mem_regwen(mem_regwen), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_regwen(wb_regwen), .wb_result(wb_result),
        .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_operand1(ex_operand1), .ex_operand2(ex_operand2), .ex_alusel(ex_alusel),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_regwen(ex_regwen),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] own);
        if (idx != 0 && mem_regwen && mem_rd == idx) return mem_result;
        if (idx != 0 && wb_regwen && wb_rd == idx) return wb_result;
        return own;
    endfunction

    function automatic logic model_stall();
        return m.v && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
    endfunction

    // Compare every output against the instruction held in the model, then clock.
    task automatic tick();
        ins_t nxt;
        logic st;
        #1;
        st = model_stall();
        chk("stall", {31'b0, stall}, {31'b0, st});
        if (!m.v) begin
            chk("bub_valid", {31'b0, ex_valid}, 32'd0);
            chk("bub_pc", ex_pc, 32'd0);
            chk("bub_op1", ex_operand1, 32'd0);
            chk("bub_op2", ex_operand2, 32'd0);
            chk("bub_store", ex_store_data, 32'd0);
            chk("bub_ctrl", {24'b0, ex_alusel, ex_rd}, 32'd0);
            chk("bub_flags", {29'b0, ex_regwen, ex_memread, ex_memwrite}, 32'd0);
        end else begin
            chk("valid", {31'b0, ex_valid}, 32'd1);
            chk("pc", ex_pc, m.pc);
            chk("op1", ex_operand1, m.asel ? m.pc : fwd(m.rs1, m.d1));
            chk("op2", ex_operand2, m.bsel ? m.imm : fwd(m.rs2, m.d2));
            chk("store", ex_store_data, fwd(m.rs2, m.d2));
            chk("ctrl", {24'b0, ex_alusel, ex_rd}, {24'b0, m.alu, m.rd});
            chk("flags", {29'b0, ex_regwen, ex_memread, ex_memwrite}, {29'b0, m.rw, m.mr, m.mw});
        end
        nxt = '0;
        if (!flush && !st && id_valid)
            nxt = '{1'b1, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
                    id_alusel, id_asel, id_bsel, id_regwen, id_memread, id_memwrite};
        last_stall = st;
        @(posedge clk);
        m = nxt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #3 rst = 1'b1;
        #1;
        chk("rst_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_op1", ex_operand1, 32'd0);
        chk("rst_op2", ex_operand2, 32'd0);
        chk("rst_store", ex_store_data, 32'd0);
        chk("rst_alusel_rd", {24'b0, ex_alusel, ex_rd}, 32'd0);
        chk("rst_flags", {29'b0, ex_regwen, ex_memread, ex_memwrite}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        m = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic rw, input logic mr, input logic mw);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_regwen = rw; id_memread = mr; id_memwrite = mw;
        id_pc = 32'h40; id_imm = 32'h3; id_alusel = 3'b000; id_asel = 1'b0; id_bsel = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; m = '0; last_stall = 1'b0;
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
        mem_rd = 5'd5; mem_regwen = 1'b1; mem_result = 32'hDEAD;
        wb_rd = 5'd0; wb_regwen = 1'b0; wb_result = 32'h0;

        // 1: reset, then again with a live instruction in EX
        do_reset();
        tick();
        do_reset();

        // 2: pass-through
        set_id(1'b1, 5'd1, 5'd2, 5'd4, 32'd7, 32'd9, 1'b1, 1'b0, 1'b0);
        id_bsel = 1'b1; mem_regwen = 1'b0; wb_regwen = 1'b0;
        tick();
        #1;
        chk("t2_op1", ex_operand1, 32'd7);
        chk("t2_op2", ex_operand2, 32'd3);
        chk("t2_rd", {27'b0, ex_rd}, 32'd4);
        chk("t2_regwen", {31'b0, ex_regwen}, 32'd1);

        // 3: dual forwarding priority, then x0 suppression
        set_id(1'b1, 5'd9, 5'd9, 5'd0, 32'hA, 32'hB, 1'b0, 1'b0, 1'b1);
        tick();
        id_valid = 1'b0;
        mem_rd = 5'd9; mem_regwen = 1'b1; mem_result = 32'h11;
        wb_rd = 5'd9; wb_regwen = 1'b1; wb_result = 32'h22;
        #1;
        chk("t3_op1_mem", ex_operand1, 32'h11);
        chk("t3_op2_mem", ex_operand2, 32'h11);
        chk("t3_st_mem", ex_store_data, 32'h11);
        mem_regwen = 1'b0;
        #1;
        chk("t3_op1_wb", ex_operand1, 32'h22);
        chk("t3_st_wb", ex_store_data, 32'h22);
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 32'h33, 32'h44, 1'b1, 1'b0, 1'b0);
        mem_rd = 5'd0; mem_regwen = 1'b1; wb_rd = 5'd0; wb_regwen = 1'b1;
        tick();
        #1;
        chk("t3_op1_x0", ex_operand1, 32'h33);
        chk("t3_st_x0", ex_store_data, 32'h44);

        // 4: load-use stall for exactly one cycle
        mem_regwen = 1'b0; wb_regwen = 1'b0;
        set_id(1'b1, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd6, 5'd7, 32'h5, 32'h6, 1'b1, 1'b0, 1'b0);
        #1;
        chk("t4_stall", {31'b0, stall}, 32'd1);
        tick();
        #1;
        chk("t4_bub_valid", {31'b0, ex_valid}, 32'd0);
        chk("t4_bub_regwen", {31'b0, ex_regwen}, 32'd0);
        chk("t4_stall_drop", {31'b0, stall}, 32'd0);
        tick();
        #1;
        chk("t4_held_valid", {31'b0, ex_valid}, 32'd1);
        chk("t4_held_rd", {27'b0, ex_rd}, 32'd7);

        // 5: flush together with stall
        set_id(1'b1, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd6, 5'd2, 5'd8, 32'h5, 32'h6, 1'b1, 1'b0, 1'b1);
        flush = 1'b1;
        #1;
        chk("t5_stall", {31'b0, stall}, 32'd1);
        tick();
        flush = 1'b0;
        #1;
        chk("t5_valid", {31'b0, ex_valid}, 32'd0);
        chk("t5_flags", {29'b0, ex_regwen, ex_memread, ex_memwrite}, 32'd0);

        // 6: asel bypasses rs1 forwarding
        set_id(1'b1, 5'd3, 5'd2, 5'd8, 32'h55, 32'h66, 1'b1, 1'b0, 1'b0);
        id_asel = 1'b1; id_pc = 32'h100;
        tick();
        mem_rd = 5'd3; mem_regwen = 1'b1; mem_result = 32'h99;
        #1;
        chk("t6_op1", ex_operand1, 32'h100);

        // Randomized traffic; ID holds its instruction while stalled
        for (int i = 0; i < 400; i++) begin
            if (!last_stall || flush) begin
                id_valid = ($urandom_range(0, 5) != 0);
                id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
                id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
                id_rd = 5'($urandom_range(0, 7)); id_alusel = 3'($urandom);
                id_asel = 1'($urandom); id_bsel = 1'($urandom); id_regwen = 1'($urandom);
                id_memread = ($urandom_range(0, 2) == 0); id_memwrite = 1'($urandom);
            end
            flush = ($urandom_range(0, 15) == 0);
            mem_rd = 5'($urandom_range(0, 7)); mem_regwen = 1'($urandom); mem_result = $urandom;
            wb_rd = 5'($urandom_range(0, 7)); wb_regwen = 1'($urandom); wb_result = $urandom;
            if (i == 200) do_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-side operand forwarding for the 5-stage core.
- Captures decoded fields from ID each cycle.
- Resolves rs1/rs2 against in-flight EX/MEM and MEM/WB results.
- Presents final operand1/operand2/alusel directly to the ALU.
- Detects load-use hazards: stalls IF/ID and inserts a bubble.

Parameters:
XLEN, 32, datapath width
RIDX, 5, register index width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  instruction PC
id_rs1_data  in  XLEN  regfile read port 1
id_rs2_data  in  XLEN  regfile read port 2
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  RIDX  source index 1
id_rs2  in  RIDX  source index 2
id_rd  in  RIDX  destination index
id_alusel  in  3  ALU op encoding
id_asel  in  1  1: operand1=PC, 0: rs1
id_bsel  in  1  1: operand2=imm, 0: rs2
id_regwen  in  1  writes rd
id_memread  in  1  load
id_memwrite  in  1  store
flush  in  1  branch/jump redirect, kill ID/EX contents
mem_rd  in  RIDX  EX/MEM destination
mem_regwen  in  1  EX/MEM writes rd
mem_result  in  XLEN  EX/MEM ALU result
wb_rd  in  RIDX  MEM/WB destination
wb_regwen  in  1  MEM/WB writes rd
wb_result  in  XLEN  MEM/WB writeback value
stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds real instruction
ex_pc  out  XLEN  registered PC
ex_operand1  out  XLEN  to ALU operand1
ex_operand2  out  XLEN  to ALU operand2
ex_alusel  out  3  to ALU alusel
ex_store_data  out  XLEN  forwarded rs2 for stores
ex_rd  out  RIDX  registered rd
ex_regwen  out  1  gated by ex_valid
ex_memread  out  1  gated by ex_valid
ex_memwrite  out  1  gated by ex_valid

Behaviour:
- Reset (async, active-high):
  - All ID/EX registers clear to 0.
  - ex_valid=0; ex_regwen/memread/memwrite=0; ex_alusel=000 (ADD); ex_rd=0; ex_pc=0.
  - ex_operand1/2=0 and ex_store_data=0: x0 is never forwarded, so these hold regardless of mem/wb inputs.
  - Reset mid-stream discards the in-flight instruction; no partial state survives.
- Register fields:
  - valid, pc, rs1/rs2 data, imm, rs1, rs2, rd, alusel, asel, bsel, regwen, memread, memwrite.
- Load-use hazard (combinational):
  - stall = ex_valid & ex_memread & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
- Next-state priority each edge:
  1. flush=1: load bubble (all fields 0).
  2. else stall=1: load bubble; upstream holds the ID instruction, which re-presents next cycle.
  3. else: capture ID fields.
  - id_valid=0 captures as a bubble.
  - flush and stall together: bubble; stall still asserted that cycle (harmless, upstream is also flushed).
- Forwarding (combinational on registered fields), computed for rs1 and rs2 independently:
  - If mem_regwen & mem_rd!=0 & mem_rd==ex_rsN: fwdN = mem_result.
  - Else if wb_regwen & wb_rd!=0 & wb_rd==ex_rsN: fwdN = wb_result.
  - Else: fwdN = registered rsN data.
  - EX/MEM wins over MEM/WB when both match.
  - Index 0 never forwards.
- Operand select:
  - ex_operand1 = asel ? ex_pc : fwd1.
  - ex_operand2 = bsel ? ex_imm : fwd2.
  - ex_store_data = fwd2 always.
- Control outputs are registered values ANDed with ex_valid. Bubbles carry alusel=000, all data fields 0.
- Latency: ID fields appear at EX outputs one cycle after capture. Forwarding adds zero cycles.
- A load-use stall lasts exactly one cycle: the load advances, and the next compare sees a bubble in EX.

Test Plan:
1. Reset: assert rst asynchronously with ID valid, mem_rd=5, mem_regwen=1, mem_result=0xDEAD -> all outputs 0 immediately; ex_alusel=000; stall=0.
2. Pass-through: id_rs1_data=7, id_imm=3, bsel=1, alusel=000, rd=4, no forwarding -> next cycle ex_operand1=7, ex_operand2=3, ex_rd=4, ex_regwen=1.
3. Dual forwarding: EX rs1=rs2=9; mem_rd=9 with mem_result=0x11; wb_rd=9 with wb_result=0x22; both regwen=1 -> operand1=0x11 and store_data=0x11. Drop mem_regwen -> both 0x22. Repeat with rd=0 matches -> registered data used.
4. Load-use: EX holds load to x6; ID valid with rs2=6 -> stall=1 for one cycle; next edge EX is a bubble (valid=0, regwen=0); the following edge captures the held instruction with stall=0.
5. Flush: flush=1 while stall=1 and ID valid -> next EX is a bubble with all control 0.
6. asel: id_asel=1, id_pc=0x100, rs1 forwarding active -> ex_operand1=0x100 (forwarding ignored for operand1).
